// File: rtl/addsub_serial_unit.sv
// Slice-serial add/subtract unit with optional signed saturation and Z/N/C/V flags.
// One SLICE-bit chunk of the carry chain is resolved per clock behind a valid/ready handshake.
module addsub_serial_unit #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             op_i,
    input  logic             sat_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic             flag_z_o,
    output logic             flag_n_o,
    output logic             flag_c_o,
    output logic             flag_v_o
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0]    LAST_SLICE = CW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SAT_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             op_q;
    logic             sat_q;
    logic [WIDTH-1:0] res_q;
    logic             flag_z_q;
    logic             flag_n_q;
    logic             flag_c_q;
    logic             flag_v_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] sum_slice;
    logic             carry_d;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] res_d;
    logic             flag_v_d;
    logic             flag_c_d;

    // b_q already holds ~b for subtraction, with the +1 entering as carry-in.
    always_comb begin
        a_slice  = a_q[int'(cnt_q)*SLICE +: SLICE];
        b_slice  = b_q[int'(cnt_q)*SLICE +: SLICE];
        {carry_d, sum_slice} = {1'b0, a_slice} + {1'b0, b_slice}
                               + {{SLICE{1'b0}}, carry_q};
        sum_d    = res_q;
        sum_d[int'(cnt_q)*SLICE +: SLICE] = sum_slice;
        flag_v_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
        flag_c_d = op_q ? ~carry_d : carry_d;
        res_d    = sum_d;
        if (sat_q && flag_v_d) begin
            res_d = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            op_q        <= 1'b0;
            sat_q       <= 1'b0;
            res_q       <= '0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        a_q        <= a_i;
                        b_q        <= op_i ? ~b_i : b_i;
                        op_q       <= op_i;
                        sat_q      <= sat_i;
                        carry_q    <= op_i;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    carry_q <= carry_d;
                    if (cnt_q == LAST_SLICE) begin
                        res_q       <= res_d;
                        flag_z_q    <= (res_d == '0);
                        flag_n_q    <= res_d[WIDTH-1];
                        flag_c_q    <= flag_c_d;
                        flag_v_q    <= flag_v_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        res_q <= sum_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign res_o       = res_q;
    assign flag_z_o    = flag_z_q;
    assign flag_n_o    = flag_n_q;
    assign flag_c_o    = flag_c_q;
    assign flag_v_o    = flag_v_q;

endmodule

// File: tb/tb_addsub_serial_unit.sv
// Bench for addsub_serial_unit: a 4-slice and a single-slice instance checked
// against a plain-arithmetic reference model.
module tb_addsub_serial_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv4, iv16, ordy4, ordy16;
    logic        op_in, sat_in;
    logic [15:0] a_in, b_in;

    logic        rdy4, ov4, z4, n4, c4, v4;
    logic [15:0] res4;
    logic        rdy16, ov16, z16, n16, c16, v16;
    logic [15:0] res16;

    int npass  = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    addsub_serial_unit #(.WIDTH(16), .SLICE(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv4), .in_ready_o(rdy4),
        .op_i(op_in), .sat_i(sat_in), .a_i(a_in), .b_i(b_in),
        .out_valid_o(ov4), .out_ready_i(ordy4), .res_o(res4),
        .flag_z_o(z4), .flag_n_o(n4), .flag_c_o(c4), .flag_v_o(v4)
    );

    addsub_serial_unit #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv16), .in_ready_o(rdy16),
        .op_i(op_in), .sat_i(sat_in), .a_i(a_in), .b_i(b_in),
        .out_valid_o(ov16), .out_ready_i(ordy16), .res_o(res16),
        .flag_z_o(z16), .flag_n_o(n16), .flag_c_o(c16), .flag_v_o(v16)
    );

    // Returns {res, z, n, c, v} from signed/unsigned integer arithmetic.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic op, input logic sat);
        int          sa, sb, s;
        logic [16:0] u;
        logic [15:0] r;
        logic        c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = op ? (sa - sb) : (sa + sb);
        u  = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        c  = op ? (a < b) : u[16];
        v  = (s > 32767) || (s < -32768);
        r  = u[15:0];
        if (sat && v) r = (s > 0) ? 16'h7FFF : 16'h8000;
        return {r, (r == 16'h0000), r[15], c, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                          input logic sat, input bit wide, input string tag);
        logic [19:0] exp;
        int          n;
        int          lat;
        exp = model(a, b, op, sat);
        n = 0;
        while (!(wide ? rdy16 : rdy4) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_rdy"}, 32'(wide ? rdy16 : rdy4), 32'd1);
        a_in = a; b_in = b; op_in = op; sat_in = sat;
        if (wide) iv16 = 1'b1; else iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; iv16 = 1'b0;
        a_in = 16'($urandom); b_in = 16'($urandom);
        op_in = 1'($urandom); sat_in = 1'($urandom);
        lat = 0;
        while (!(wide ? ov16 : ov4) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_lat"}, 32'(lat), wide ? 32'd1 : 32'd4);
        if (wide) chk({tag, "_rzncv"}, {12'd0, res16, z16, n16, c16, v16}, {12'd0, exp});
        else      chk({tag, "_rzncv"}, {12'd0, res4, z4, n4, c4, v4}, {12'd0, exp});
        chk({tag, "_busy"}, 32'(wide ? rdy16 : rdy4), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_hs"}, {30'd0, (wide ? ov16 : ov4), (wide ? rdy16 : rdy4)}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] exp;
        int          seen;

        rst_n = 1'b0; iv4 = 1'b0; iv16 = 1'b0; ordy4 = 1'b1; ordy16 = 1'b1;
        op_in = 1'b0; sat_in = 1'b0; a_in = '0; b_in = '0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            iv4 = 1'($urandom); iv16 = 1'($urandom);
            a_in = 16'($urandom); b_in = 16'($urandom);
            op_in = 1'($urandom); sat_in = 1'($urandom);
        end
        chk("rst_out4", {10'd0, ov4, res4, z4, n4, c4, v4}, 32'd0);
        chk("rst_out16", {10'd0, ov16, res16, z16, n16, c16, v16}, 32'd0);
        rst_n = 1'b1; iv4 = 1'b0; iv16 = 1'b0;
        @(posedge clk); #1;
        chk("rst_rdy", {30'd0, rdy4, ov4}, 32'b10);

        // Directed arithmetic and boundary cases
        run_op(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0, "sub5m3");
        run_op(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0, "sub3m5");
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, "sub0m0");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "addovf");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, "addsat");
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, "subsat");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "addwrap");

        // Random operations
        for (int i = 0; i < 20; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rnd");
        end

        // Backpressure: result held, new request ignored
        ordy4 = 1'b0;
        exp = model(16'h1234, 16'h0F0F, 1'b0, 1'b0);
        a_in = 16'h1234; b_in = 16'h0F0F; op_in = 1'b0; sat_in = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        seen = 0;
        while (!ov4 && seen < 20) begin
            @(posedge clk); #1; seen++;
        end
        chk("bp_lat", 32'(seen), 32'd4);
        iv4 = 1'b1; a_in = 16'hAAAA; b_in = 16'h5555; op_in = 1'b1; sat_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", {10'd0, ov4, rdy4, res4, z4, n4, c4, v4},
                {10'd0, 1'b1, 1'b0, exp});
        end
        iv4 = 1'b0; ordy4 = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs", {30'd0, ov4, rdy4}, 32'b01);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ov4) seen++;
        end
        chk("bp_noop", 32'(seen), 32'd0);

        // Reset during CALC discards the operation
        a_in = 16'h0005; b_in = 16'h0003; op_in = 1'b1; sat_in = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_out", {10'd0, ov4, res4, z4, n4, c4, v4}, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ov4) seen++;
        end
        chk("mrst_noval", 32'(seen), 32'd0);
        chk("mrst_rdy", 32'(rdy4), 32'd1);

        // Single-slice instance
        run_op(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1, "w16_sub");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, "w16_sat");
        for (int i = 0; i < 5; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, "w16_rnd");
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
